// File: rtl/enemy_box_renderer.sv
// Purpose: serialises erase/draw of three enemy boxes into one pixel-write stream for the VGA adapter.
// Latency: tick accepted at edge T -> first pixel at T+2, done two cycles after the last sweep cycle.
// Backpressure: none; frame_tick pulses arriving while busy (including the done cycle) are dropped.
module enemy_box_renderer #(
  parameter int          BOX       = 4,
  parameter int          XMAX      = 160,
  parameter int          YMAX      = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic [7:0] enemy1_x,
  input  logic [7:0] enemy2_x,
  input  logic [7:0] enemy3_x,
  input  logic [7:0] enemy1_y,
  input  logic [7:0] enemy2_y,
  input  logic [7:0] enemy3_y,
  input  logic [2:0] enemy1_c,
  input  logic [2:0] enemy2_c,
  input  logic [2:0] enemy3_c,
  input  logic       enemy1_p,
  input  logic       enemy2_p,
  input  logic       enemy3_p,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       busy,
  output logic       done
);

  localparam int LB = $clog2(BOX);
  // A 1-pixel box still needs a 1-bit counter that simply never advances.
  localparam int CW = (LB == 0) ? 1 : 2 * LB;
  localparam logic [CW-1:0] CNT_LAST = CW'(BOX * BOX - 1);
  localparam logic [8:0] XLIM = 9'(XMAX);
  localparam logic [8:0] YLIM = 9'(YMAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ERASE  = 2'd1;
  localparam logic [1:0] S_DRAW   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]    state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;

  // Shadow copies of the enemy inputs, frozen for the whole refresh.
  logic [7:0] sx [0:2];
  logic [7:0] sy [0:2];
  logic [2:0] sc [0:2];
  logic [2:0] sp;

  // What is actually on screen from the previous refresh.
  logic [7:0] last_x [0:2];
  logic [7:0] last_y [0:2];
  logic [2:0] last_v;

  logic       ph_act;
  logic [7:0] base_x;
  logic [7:0] base_y;
  logic [2:0] ph_col;
  logic [8:0] px;
  logic [8:0] py;
  logic [8:0] pix_x;
  logic [8:0] pix_y;
  logic       phase_end;
  logic       accept;

  assign px        = 9'(cnt) & 9'(BOX - 1);
  assign py        = 9'(cnt) >> LB;
  assign pix_x     = {1'b0, base_x} + px;
  assign pix_y     = {1'b0, base_y} + py;
  assign phase_end = !ph_act || (cnt == CNT_LAST);
  assign accept    = (state == S_IDLE) && frame_tick && !busy;

  // Select the box being swept: old history box when erasing, shadow box when drawing.
  always_comb begin
    ph_act = 1'b0;
    base_x = 8'd0;
    base_y = 8'd0;
    ph_col = BG_COLOUR;
    if (state == S_ERASE) begin
      ph_act = last_v[idx];
      base_x = last_x[idx];
      base_y = last_y[idx];
      ph_col = BG_COLOUR;
    end else if (state == S_DRAW) begin
      ph_act = sp[idx];
      base_x = sx[idx];
      base_y = sy[idx];
      ph_col = sc[idx];
    end
  end

  // Sequencer plus registered pixel outputs; one pixel (or one skip cycle) per clock.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      state   <= S_IDLE;
      idx     <= 2'd0;
      cnt     <= '0;
      sp      <= 3'b000;
      last_v  <= 3'b000;
      x       <= 8'd0;
      y       <= 8'd0;
      colour  <= 3'd0;
      writeEn <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        sx[k]     <= 8'd0;
        sy[k]     <= 8'd0;
        sc[k]     <= 3'd0;
        last_x[k] <= 8'd0;
        last_y[k] <= 8'd0;
      end
    end else begin
      writeEn <= 1'b0;
      done    <= 1'b0;
      // busy trails the state by one cycle so it also covers the done cycle.
      busy    <= accept || (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (accept) begin
            sx[0] <= enemy1_x;  sx[1] <= enemy2_x;  sx[2] <= enemy3_x;
            sy[0] <= enemy1_y;  sy[1] <= enemy2_y;  sy[2] <= enemy3_y;
            sc[0] <= enemy1_c;  sc[1] <= enemy2_c;  sc[2] <= enemy3_c;
            sp    <= {enemy3_p, enemy2_p, enemy1_p};
            idx   <= 2'd0;
            cnt   <= '0;
            state <= S_ERASE;
          end
        end
        S_ERASE, S_DRAW: begin
          if (ph_act) begin
            x       <= pix_x[7:0];
            y       <= pix_y[7:0];
            colour  <= ph_col;
            // Off-screen pixels still take their cycle but are never plotted.
            writeEn <= (pix_x < XLIM) && (pix_y < YLIM);
          end
          if (phase_end) begin
            cnt <= '0;
            if (state == S_ERASE) begin
              state <= S_DRAW;
            end else begin
              last_x[idx] <= sx[idx];
              last_y[idx] <= sy[idx];
              last_v[idx] <= sp[idx];
              if (idx == 2'd2) begin
                state <= S_FINISH;
              end else begin
                idx   <= idx + 2'd1;
                state <= S_ERASE;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_box_renderer.sv
// Bench for enemy_box_renderer: table vectors, hand corner sequences and random refreshes.
// Expected pixel streams come from a box-list model of erase/draw with screen clipping.
// Done latency is the sum of phase lengths plus two cycles.
module tb_enemy_box_renderer;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
    logic       p;
  } ent_t;

  typedef struct packed {
    ent_t e1;
    ent_t e2;
    ent_t e3;
    int   exp_done;
    int   exp_wr;
    bit   extra;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] cur_x [3];
  logic [7:0] cur_y [3];
  logic [2:0] cur_c [3];
  logic       cur_p [3];
  logic [7:0] x, y;
  logic [2:0] colour;
  logic       writeEn, busy, done;

  int total = 0;
  int bad = 0;

  // Model of what is on screen: box list from the last completed refresh.
  logic [7:0]  hx [3];
  logic [7:0]  hy [3];
  logic        hv [3];
  logic [18:0] exp_q [$];

  vec_t tv [6];

  always #5 clock = ~clock;

  enemy_box_renderer dut (
    .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick),
    .enemy1_x(cur_x[0]), .enemy2_x(cur_x[1]), .enemy3_x(cur_x[2]),
    .enemy1_y(cur_y[0]), .enemy2_y(cur_y[1]), .enemy3_y(cur_y[2]),
    .enemy1_c(cur_c[0]), .enemy2_c(cur_c[1]), .enemy3_c(cur_c[2]),
    .enemy1_p(cur_p[0]), .enemy2_p(cur_p[1]), .enemy3_p(cur_p[2]),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy), .done(done)
  );

  function automatic ent_t mk(input int ex, input int ey, input int ec, input int ep);
    ent_t e;
    e.x = 8'(ex);
    e.y = 8'(ey);
    e.c = 3'(ec);
    e.p = 1'(ep);
    return e;
  endfunction

  task automatic set_ent(input int i, input ent_t e);
    cur_x[i] = e.x;
    cur_y[i] = e.y;
    cur_c[i] = e.c;
    cur_p[i] = e.p;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_history();
    for (int i = 0; i < 3; i++) begin
      hx[i] = 8'd0;
      hy[i] = 8'd0;
      hv[i] = 1'b0;
    end
  endtask

  // Push every on-screen pixel of one 4x4 box in row-major order; return cycles spent.
  function automatic int sweep_box(input logic [7:0] bx, input logic [7:0] by,
                                   input logic [2:0] c, input logic vis);
    int px, py;
    if (!vis) return 1;
    for (int r = 0; r < 4; r++) begin
      for (int q = 0; q < 4; q++) begin
        px = int'(bx) + q;
        py = int'(by) + r;
        if (px < 160 && py < 120)
          exp_q.push_back({px[7:0], py[7:0], c});
      end
    end
    return 16;
  endfunction

  function automatic int build_model();
    int cyc = 0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      cyc += sweep_box(hx[i], hy[i], 3'b000, hv[i]);
      cyc += sweep_box(cur_x[i], cur_y[i], cur_c[i], cur_p[i]);
    end
    return cyc;
  endfunction

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_x"}, int'(x), 0);
    chk({nm, "_y"}, int'(y), 0);
    chk({nm, "_colour"}, int'(colour), 0);
    chk({nm, "_we"}, int'(writeEn), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
  endtask

  // One refresh: pulse the tick, collect writes until done, compare against the model.
  // exp_done/exp_wr < 0 means take them from the model. reset_at > 0 resets after that many writes.
  task automatic do_refresh(input string nm, input int exp_done, input int exp_wr,
                            input bit extra, input int reset_at);
    int cyc, nexp, n, nwr, got_done;
    logic [18:0] e;
    cyc  = build_model();
    nexp = exp_q.size();
    frame_tick = 1'b1;
    @(posedge clock); #1;
    frame_tick = 1'b0;
    n = 1; nwr = 0; got_done = 0;
    chk({nm, "_busy_rise"}, int'(busy), 1);
    while (got_done == 0 && n < 400) begin
      if (writeEn) begin
        if (exp_q.size() == 0) begin
          chk({nm, "_extra_write"}, int'({x, y, colour}), 0);
        end else begin
          e = exp_q.pop_front();
          chk({nm, "_pixel"}, int'({x, y, colour}), int'(e));
        end
        nwr++;
        if (reset_at > 0 && nwr == reset_at) begin
          reset_n = 1'b1;
          @(posedge clock); #1;
          reset_n = 1'b0;
          check_reset_outputs({nm, "_midrst"});
          clear_history();
          return;
        end
      end
      if (done) begin
        got_done = n;
      end else begin
        chk({nm, "_busy_hold"}, int'(busy), 1);
        frame_tick = (extra && (n == 3 || n == 40)) ? 1'b1 : 1'b0;
        @(posedge clock); #1;
        n++;
      end
    end
    frame_tick = 1'b0;
    if (got_done == 0) begin
      chk({nm, "_timeout"}, 0, 1);
      return;
    end
    chk({nm, "_done_lat"}, got_done, exp_done >= 0 ? exp_done : cyc + 2);
    chk({nm, "_writes"}, nwr, exp_wr >= 0 ? exp_wr : nexp);
    chk({nm, "_leftover"}, exp_q.size(), 0);
    chk({nm, "_busy_on_done"}, int'(busy), 1);
    // A tick on the done cycle must be dropped as well.
    if (extra) frame_tick = 1'b1;
    @(posedge clock); #1;
    frame_tick = 1'b0;
    chk({nm, "_busy_fall"}, int'(busy), 0);
    chk({nm, "_done_pulse"}, int'(done), 0);
    for (int i = 0; i < 4; i++) begin
      if (writeEn || busy) chk({nm, "_quiet"}, int'({writeEn, busy}), 0);
      @(posedge clock); #1;
    end
    for (int i = 0; i < 3; i++) begin
      hx[i] = cur_x[i];
      hy[i] = cur_y[i];
      hv[i] = cur_p[i];
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) set_ent(i, mk(0, 0, 0, 0));
    clear_history();

    tv[0] = '{mk(40, 60, 4, 1),  mk(0, 0, 0, 0),     mk(0, 0, 0, 0),     23, 16, 1'b0};
    tv[1] = '{mk(41, 61, 4, 1),  mk(0, 0, 0, 0),     mk(0, 0, 0, 0),     38, 32, 1'b0};
    tv[2] = '{mk(41, 61, 4, 0),  mk(158, 118, 2, 1), mk(0, 0, 0, 0),     38, 20, 1'b0};
    tv[3] = '{mk(41, 61, 4, 0),  mk(158, 118, 2, 0), mk(0, 0, 0, 0),     23, 4,  1'b0};
    tv[4] = '{mk(10, 20, 1, 1),  mk(100, 50, 5, 1),  mk(0, 0, 7, 1),     53, 48, 1'b0};
    tv[5] = '{mk(11, 20, 1, 1),  mk(100, 51, 5, 1),  mk(156, 116, 3, 1), 98, 96, 1'b1};

    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b0;
    @(posedge clock); #1;

    for (int v = 0; v < 6; v++) begin
      set_ent(0, tv[v].e1);
      set_ent(1, tv[v].e2);
      set_ent(2, tv[v].e3);
      do_refresh($sformatf("vec%0d", v), tv[v].exp_done, tv[v].exp_wr, tv[v].extra, 0);
    end

    // Reset lands on the 20th pixel of a full refresh.
    set_ent(0, mk(20, 30, 6, 1));
    set_ent(1, mk(60, 70, 2, 1));
    set_ent(2, mk(90, 10, 4, 1));
    do_refresh("midrst", -1, -1, 1'b0, 20);
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("post_rst");
    // History was wiped, so this refresh has no erase phases.
    do_refresh("after_rst", 53, 48, 1'b0, 0);

    // Reset and tick in the same cycle: reset wins, nothing starts.
    reset_n = 1'b1;
    frame_tick = 1'b1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    frame_tick = 1'b0;
    clear_history();
    @(posedge clock); #1;
    chk("rst_tick_busy", int'(busy), 0);
    @(posedge clock); #1;
    chk("rst_tick_we", int'(writeEn), 0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 3; i++)
        set_ent(i, mk($urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 7), $urandom_range(0, 1)));
      do_refresh($sformatf("rand%0d", r), -1, -1, 1'(r % 2), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
